register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 12 +
 rtl/register_file_scoreboard.sv | 90 +++++++++
 rtl/register_file.sv | 84 ++++++++
 tb/tb_register_file.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared core constants: register/data geometry and the in-flight count type
// used by the register file and its hazard scoreboard.
package register_file_pkg;

   localparam int DATA_WIDTH_DEF = 64;
   localparam int REG_ADDR_W_DEF = 5;
   localparam int CNT_W_DEF      = 2;
   localparam int NUM_REGS_DEF   = 2 ** REG_ADDR_W_DEF;

   typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/register_file_scoreboard.sv
// Per-register in-flight write counters; produces source-busy flags and the
// issue stall, all combinational from the counters and current inputs.
module reg_scoreboard
   import register_file_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_arstn,
   input  logic [REG_ADDR_W-1:0] i_rs1_addr,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr,
   input  logic                  i_issue_valid,
   input  logic [REG_ADDR_W-1:0] i_issue_rd_addr,
   input  logic                  i_issue_reg_we,
   input  logic                  i_wb_we,
   input  logic [REG_ADDR_W-1:0] i_wb_addr,
   input  logic                  i_flush,
   output logic                  o_rs1_busy,
   output logic                  o_rs2_busy,
   output logic                  o_stall
);

   localparam int NUM_REGS = 2 ** REG_ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0]    cnt_q [NUM_REGS];
   logic [CNT_W-1:0]    cnt_d [NUM_REGS];
   logic [NUM_REGS-1:0] wb_hit;
   logic [NUM_REGS-1:0] iss_hit;
   logic                issue_rd_nz;
   logic                issue_ok;
   logic                rd_full;
   logic                rs1_busy;
   logic                rs2_busy;
   logic                stall;

   // i_wb_we arrives already qualified with a nonzero destination.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
         assign wb_hit[gi]  = i_wb_we && (i_wb_addr == REG_ADDR_W'(gi));
         assign iss_hit[gi] = issue_ok && (i_issue_rd_addr == REG_ADDR_W'(gi));
      end
   endgenerate

   assign issue_rd_nz = (i_issue_rd_addr != '0);

   always_comb begin
      rs1_busy = (i_rs1_addr != '0) && (cnt_q[i_rs1_addr] != '0) &&
                 !((cnt_q[i_rs1_addr] == CNT_ONE) && wb_hit[i_rs1_addr]);
      rs2_busy = (i_rs2_addr != '0) && (cnt_q[i_rs2_addr] != '0) &&
                 !((cnt_q[i_rs2_addr] == CNT_ONE) && wb_hit[i_rs2_addr]);
      // A saturated destination only blocks issue if nothing retires it now.
      rd_full  = i_issue_reg_we && issue_rd_nz &&
                 (cnt_q[i_issue_rd_addr] == CNT_MAX) && !wb_hit[i_issue_rd_addr];
      stall    = i_issue_valid && (rs1_busy || rs2_busy || rd_full);
   end

   assign issue_ok = i_issue_valid && i_issue_reg_we && issue_rd_nz && !stall;

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (i_flush) begin
            cnt_d[i] = '0;
         end else if (iss_hit[i] && !wb_hit[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end else if (!iss_hit[i] && wb_hit[i] && (cnt_q[i] != '0)) begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_rs1_busy = rs1_busy;
   assign o_rs2_busy = rs2_busy;
   assign o_stall    = stall;

endmodule

// File: rtl/register_file.sv
// Two-read/one-write integer register file with write-through bypass and an
// in-flight write scoreboard that flags RAW hazards and refuses issue.
module register_file
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_arstn,
   input  logic [REG_ADDR_W-1:0] i_rs1_addr,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr,
   output logic [DATA_WIDTH-1:0] o_rs1_data,
   output logic [DATA_WIDTH-1:0] o_rs2_data,
   input  logic [REG_ADDR_W-1:0] i_rd_addr,
   input  logic [DATA_WIDTH-1:0] i_result,
   input  logic                  i_reg_we,
   input  logic                  i_issue_valid,
   input  logic [REG_ADDR_W-1:0] i_issue_rd_addr,
   input  logic                  i_issue_reg_we,
   input  logic                  i_flush,
   output logic                  o_rs1_busy,
   output logic                  o_rs2_busy,
   output logic                  o_stall
);

   localparam int NUM_REGS = 2 ** REG_ADDR_W;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic                  wb_we;

   assign wb_we = i_reg_we && (i_rd_addr != '0);

   always_comb begin
      regs_d = regs_q;
      if (wb_we) begin
         regs_d[i_rd_addr] = i_result;
      end
   end

   // Entries are flops, not block RAM: reset must clear them asynchronously.
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      o_rs1_data = '0;
      o_rs2_data = '0;
      if (i_rs1_addr != '0) begin
         o_rs1_data = (wb_we && (i_rd_addr == i_rs1_addr)) ? i_result : regs_q[i_rs1_addr];
      end
      if (i_rs2_addr != '0) begin
         o_rs2_data = (wb_we && (i_rd_addr == i_rs2_addr)) ? i_result : regs_q[i_rs2_addr];
      end
   end

   reg_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W),
      .CNT_W      (CNT_W)
   ) u_scoreboard (
      .i_clk           (i_clk),
      .i_arstn         (i_arstn),
      .i_rs1_addr      (i_rs1_addr),
      .i_rs2_addr      (i_rs2_addr),
      .i_issue_valid   (i_issue_valid),
      .i_issue_rd_addr (i_issue_rd_addr),
      .i_issue_reg_we  (i_issue_reg_we),
      .i_wb_we         (wb_we),
      .i_wb_addr       (i_rd_addr),
      .i_flush         (i_flush),
      .o_rs1_busy      (o_rs1_busy),
      .o_rs2_busy      (o_rs2_busy),
      .o_stall         (o_stall)
   );

endmodule

// File: tb/tb_register_file.sv
// Directed and randomized checks of register_file against an array/counter
// reference model of the register and in-flight-write rules.
module tb_register_file;

   localparam int DW   = 64;
   localparam int AW   = 5;
   localparam int NREG = 32;
   localparam int CMAX = 3;

   logic          i_clk = 1'b0;
   logic          i_arstn;
   logic [AW-1:0] i_rs1_addr, i_rs2_addr, i_rd_addr, i_issue_rd_addr;
   logic [DW-1:0] i_result;
   logic          i_reg_we, i_issue_valid, i_issue_reg_we, i_flush;
   logic [DW-1:0] o_rs1_data, o_rs2_data;
   logic          o_rs1_busy, o_rs2_busy, o_stall;

   logic [DW-1:0] m_mem [NREG];
   int            m_cnt [NREG];
   int            total = 0;
   int            bad   = 0;

   register_file dut (
      .i_clk           (i_clk),
      .i_arstn         (i_arstn),
      .i_rs1_addr      (i_rs1_addr),
      .i_rs2_addr      (i_rs2_addr),
      .o_rs1_data      (o_rs1_data),
      .o_rs2_data      (o_rs2_data),
      .i_rd_addr       (i_rd_addr),
      .i_result        (i_result),
      .i_reg_we        (i_reg_we),
      .i_issue_valid   (i_issue_valid),
      .i_issue_rd_addr (i_issue_rd_addr),
      .i_issue_reg_we  (i_issue_reg_we),
      .i_flush         (i_flush),
      .o_rs1_busy      (o_rs1_busy),
      .o_rs2_busy      (o_rs2_busy),
      .o_stall         (o_stall)
   );

   always #5 i_clk = ~i_clk;

   function automatic bit wb_to(input logic [AW-1:0] a);
      return i_reg_we && (i_rd_addr != 0) && (i_rd_addr == a);
   endfunction

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (wb_to(a)) return i_result;
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      if (a == 0) return 1'b0;
      if (m_cnt[a] == 0) return 1'b0;
      if (m_cnt[a] == 1 && wb_to(a)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic exp_stall();
      bit full;
      full = i_issue_reg_we && (i_issue_rd_addr != 0) &&
             (m_cnt[i_issue_rd_addr] == CMAX) && !wb_to(i_issue_rd_addr);
      return i_issue_valid && (exp_busy(i_rs1_addr) || exp_busy(i_rs2_addr) || full);
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      #1;
      chk({tag, ".rs1_data"}, o_rs1_data, exp_data(i_rs1_addr));
      chk({tag, ".rs2_data"}, o_rs2_data, exp_data(i_rs2_addr));
      chk({tag, ".rs1_busy"}, DW'(o_rs1_busy), DW'(exp_busy(i_rs1_addr)));
      chk({tag, ".rs2_busy"}, DW'(o_rs2_busy), DW'(exp_busy(i_rs2_addr)));
      chk({tag, ".stall"}, DW'(o_stall), DW'(exp_stall()));
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_mem[i] = '0;
         m_cnt[i] = 0;
      end
   endtask

   // Advance one clock and apply the register/count rules to the model.
   task automatic tick();
      bit acc, wb;
      acc = i_issue_valid && i_issue_reg_we && (i_issue_rd_addr != 0) && !exp_stall();
      wb  = i_reg_we && (i_rd_addr != 0);
      @(posedge i_clk);
      if (wb) m_mem[i_rd_addr] = i_result;
      if (i_flush) begin
         for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
      end else if (acc && wb && i_issue_rd_addr == i_rd_addr) begin
         // retire and re-issue cancel out
      end else begin
         if (acc) m_cnt[i_issue_rd_addr] = m_cnt[i_issue_rd_addr] + 1;
         if (wb && m_cnt[i_rd_addr] > 0) m_cnt[i_rd_addr] = m_cnt[i_rd_addr] - 1;
      end
      @(negedge i_clk);
   endtask

   task automatic idle();
      i_rs1_addr = 0; i_rs2_addr = 0; i_rd_addr = 0; i_result = '0;
      i_reg_we = 0; i_issue_valid = 0; i_issue_rd_addr = 0;
      i_issue_reg_we = 0; i_flush = 0;
   endtask

   task automatic issue(input logic [AW-1:0] rd);
      idle();
      i_issue_valid = 1; i_issue_reg_we = 1; i_issue_rd_addr = rd;
      check_all("issue");
      tick();
   endtask

   initial begin
      idle();
      i_arstn = 1'b0;
      model_reset();
      #2;
      i_rs1_addr = 5;
      check_all("in_reset");
      @(negedge i_clk);
      @(negedge i_clk);
      i_arstn = 1'b1;

      // reset state read
      i_rs1_addr = 5; i_rs2_addr = 0; i_issue_valid = 1;
      check_all("post_reset");
      chk("post_reset.stall_const", DW'(o_stall), DW'(0));
      idle();

      // write x5 with same-cycle bypass
      i_reg_we = 1; i_rd_addr = 5; i_result = 64'hDEAD_BEEF; i_rs1_addr = 5;
      check_all("wr_x5");
      chk("wr_x5.bypass_const", o_rs1_data, 64'hDEAD_BEEF);
      tick();
      idle(); i_rs1_addr = 5;
      check_all("rd_x5");
      chk("rd_x5.const", o_rs1_data, 64'hDEAD_BEEF);

      // write to x0 is dropped
      i_reg_we = 1; i_rd_addr = 0; i_result = 64'h1234; i_rs1_addr = 0;
      check_all("wr_x0");
      tick();
      idle(); i_rs2_addr = 0;
      check_all("rd_x0");
      chk("rd_x0.const", o_rs2_data, 64'h0);

      // RAW hazard on x7, resolved by same-cycle write-back
      issue(7);
      idle();
      i_issue_valid = 1; i_rs2_addr = 7;
      check_all("raw_x7");
      chk("raw_x7.busy_const", DW'(o_rs2_busy), DW'(1));
      chk("raw_x7.stall_const", DW'(o_stall), DW'(1));
      i_reg_we = 1; i_rd_addr = 7; i_result = 64'h42;
      check_all("raw_x7_wb");
      chk("raw_x7_wb.busy_const", DW'(o_rs2_busy), DW'(0));
      chk("raw_x7_wb.stall_const", DW'(o_stall), DW'(0));
      chk("raw_x7_wb.data_const", o_rs2_data, 64'h42);
      tick();

      // counter saturation on x3
      issue(3); issue(3); issue(3);
      idle();
      i_issue_valid = 1; i_issue_reg_we = 1; i_issue_rd_addr = 3;
      check_all("sat_x3");
      chk("sat_x3.stall_const", DW'(o_stall), DW'(1));
      tick();
      i_reg_we = 1; i_rd_addr = 3; i_result = 64'h33;
      check_all("sat_x3_wb");
      chk("sat_x3_wb.stall_const", DW'(o_stall), DW'(0));
      tick();
      idle(); i_rs1_addr = 3;
      check_all("sat_x3_hold");
      chk("sat_x3_hold.cnt_model", 64'(m_cnt[3]), 64'd3);

      // flush clears counts but still writes the array
      i_flush = 1;
      check_all("pre_flush");
      tick();
      issue(9); issue(9);
      idle();
      i_flush = 1; i_reg_we = 1; i_rd_addr = 9; i_result = 64'h77;
      check_all("flush_wb");
      tick();
      idle(); i_rs1_addr = 9; i_rs2_addr = 3;
      check_all("after_flush");
      chk("after_flush.busy_const", DW'(o_rs1_busy), DW'(0));
      chk("after_flush.data_const", o_rs1_data, 64'h77);

      // asynchronous reset mid-cycle
      issue(4); issue(4);
      idle();
      i_reg_we = 1; i_rd_addr = 4; i_result = 64'h5;
      check_all("x4_wb");
      tick();
      idle(); i_rs1_addr = 4;
      check_all("x4_busy");
      chk("x4_busy.const", DW'(o_rs1_busy), DW'(1));
      #2;
      i_arstn = 1'b0;
      model_reset();
      #1;
      chk("async_rst.data", o_rs1_data, 64'h0);
      chk("async_rst.busy", DW'(o_rs1_busy), DW'(0));
      @(negedge i_clk);
      i_arstn = 1'b1;

      // randomized traffic over a narrow address range to provoke hazards
      for (int n = 0; n < 400; n++) begin
         i_rs1_addr      = AW'($urandom_range(0, 7));
         i_rs2_addr      = AW'($urandom_range(0, 7));
         i_rd_addr       = AW'($urandom_range(0, 7));
         i_result        = {$urandom, $urandom};
         i_reg_we        = ($urandom_range(0, 9) < 4);
         i_issue_valid   = ($urandom_range(0, 1) == 1);
         i_issue_reg_we  = ($urandom_range(0, 3) != 0);
         i_issue_rd_addr = AW'($urandom_range(0, 7));
         i_flush         = ($urandom_range(0, 29) == 0);
         check_all("rand");
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
